dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 107 ++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester (core / host) data-memory arbiter: a three-state access FSM
// with round-robin arbitration, host exclusive lock and fully registered outputs.
module dmem_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic              host_lock,
    output logic              core_ack,
    output logic              host_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic {OWNER_CORE, OWNER_HOST} owner_t;

    state_t state;
    owner_t owner;
    owner_t last_owner;
    logic   acc_we;

    logic core_elig;
    logic host_elig;
    logic grant_core;
    logic grant_host;

    // A requester that is being acked this cycle still holds its request, so
    // it is masked to avoid re-granting a request that has just completed.
    always_comb begin
        core_elig  = core_req & ~host_lock & ~core_ack;
        host_elig  = host_req & ~host_ack;
        grant_core = core_elig & (~host_elig | (last_owner == OWNER_HOST));
        grant_host = host_elig & ~grant_core;
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= OWNER_HOST;
            last_owner <= OWNER_HOST;
            acc_we     <= 1'b0;
            core_ack   <= 1'b0;
            host_ack   <= 1'b0;
            rdata      <= '0;
            busy       <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
        end else begin
            // Pulses default low; each is raised for a single cycle below.
            core_ack  <= 1'b0;
            host_ack  <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_core || grant_host) begin
                        owner      <= grant_core ? OWNER_CORE : OWNER_HOST;
                        last_owner <= grant_core ? OWNER_CORE : OWNER_HOST;
                        acc_we     <= grant_core ? core_we : host_we;
                        mem_addr   <= grant_core ? core_addr : host_addr;
                        mem_wdata  <= grant_core ? core_wdata : host_wdata;
                        mem_read   <= grant_core ? ~core_we : ~host_we;
                        mem_write  <= grant_core ? core_we : host_we;
                        busy       <= 1'b1;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    state <= RESP;
                end
                RESP: begin
                    if (!acc_we) begin
                        rdata <= mem_rdata;
                    end
                    core_ack <= (owner == OWNER_CORE);
                    host_ack <= (owner == OWNER_HOST);
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
